// File: rtl/gba_io_pkg.sv
// Shared types for the PSRAM memory controller: FSM state encoding, access
// width codes and small decode helpers.
package gba_io_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } mem_state_e;

  localparam logic [1:0] W8  = 2'b01;
  localparam logic [1:0] W16 = 2'b10;
  localparam logic [1:0] W32 = 2'b11;

  // Width 00 has no byte/word meaning of its own and behaves as a halfword.
  function automatic logic [1:0] norm_width(input logic [1:0] width);
    return (width == 2'b00) ? W16 : width;
  endfunction

  function automatic logic is_active(input mem_state_e st);
    return (st == RD_LO) || (st == RD_HI) || (st == WR_LO) || (st == WR_HI);
  endfunction

  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] low_addr);
    return ((width == W16) && low_addr[0]) || ((width == W32) && (low_addr != 2'b00));
  endfunction

endpackage

// File: rtl/mux_mem_interface.sv
// Request/response bus between the memory mux and a memory controller.
interface mux_mem_interface;
  logic [25:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_wr_data;
  logic        mem_rd_ready;
  logic        mem_wr_ready;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;

  modport mem (
    input  mem_addr, mem_rd, mem_wr, mem_data_width, mem_wr_data,
    output mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
  );

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_data_width, mem_wr_data,
    input  mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Strobe-hold timer: load starts a WAIT_CYCLES-long window, done marks its
// final cycle.
module mem_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(WAIT_CYCLES - 1);
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/psram_mem_ctrl.sv
// Asynchronous PSRAM controller: splits 8/16/32-bit bus requests into 16-bit
// strobe cycles. Define MEM_CTRL_ALIGN_CHECK_EN to enable the sticky mem_err flag.
module psram_mem_ctrl
  import gba_io_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_mem_interface.mem    mem,
  output logic [24:0]      sram_addr,
  output logic [15:0]      sram_dq_o,
  output logic             sram_dq_oe,
  input  logic [15:0]      sram_dq_i,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic             sram_ub_n,
  output logic             sram_lb_n,
  output logic             mem_err
);

  mem_state_e  state;
  mem_state_e  next_state;
  logic [25:0] addr_q;
  logic [1:0]  width_q;
  logic [31:0] wr_data_q;
  logic [15:0] lo_q;
  logic        rd_q;
  logic        rd_accept;
  logic        wr_accept;
  logic        wait_load;
  logic        wait_done;
  logic [24:0] word_addr;

  // A simultaneous write is left pending on the bus rather than consumed.
  assign rd_accept = (state == IDLE) && mem.mem_rd;
  assign wr_accept = (state == IDLE) && mem.mem_wr && !mem.mem_rd;
  assign wait_load = is_active(next_state) && (next_state != state);
  assign word_addr = addr_q[25:1];

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (wait_load),
    .done (wait_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rd_accept)      next_state = RD_LO;
        else if (wr_accept) next_state = WR_LO;
      end
      RD_LO: if (wait_done) next_state = (width_q == W32) ? RD_HI : DONE;
      RD_HI: if (wait_done) next_state = DONE;
      WR_LO: if (wait_done) next_state = (width_q == W32) ? WR_HI : DONE;
      WR_HI: if (wait_done) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= 26'd0;
      width_q         <= W16;
      wr_data_q       <= 32'd0;
      lo_q            <= 16'd0;
      rd_q            <= 1'b0;
      mem.mem_rd_data <= 32'd0;
    end else begin
      if (rd_accept || wr_accept) begin
        addr_q    <= mem.mem_addr;
        width_q   <= norm_width(mem.mem_data_width);
        wr_data_q <= mem.mem_wr_data;
        rd_q      <= rd_accept;
      end
      // The low half of a 32-bit read is staged so mem_rd_data only changes once.
      if ((state == RD_LO) && wait_done) begin
        if (width_q == W32)     lo_q <= sram_dq_i;
        else if (width_q == W8) mem.mem_rd_data <= {24'd0, addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0]};
        else                    mem.mem_rd_data <= {16'd0, sram_dq_i};
      end
      if ((state == RD_HI) && wait_done) mem.mem_rd_data <= {sram_dq_i, lo_q};
    end
  end

  always_comb begin
    sram_addr         = 25'd0;
    sram_dq_o         = 16'd0;
    sram_dq_oe        = 1'b0;
    sram_ce_n         = 1'b1;
    sram_oe_n         = 1'b1;
    sram_we_n         = 1'b1;
    sram_ub_n         = 1'b1;
    sram_lb_n         = 1'b1;
    mem.mem_rd_ready  = (state == IDLE);
    mem.mem_wr_ready  = (state == IDLE);
    mem.mem_rd_valid  = (state == DONE) && rd_q;
    if (is_active(state)) begin
      sram_ce_n = 1'b0;
      sram_addr = ((state == RD_HI) || (state == WR_HI)) ? word_addr + 25'd1 : word_addr;
      if (width_q == W8) begin
        sram_ub_n = !addr_q[0];
        sram_lb_n = addr_q[0];
      end else begin
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
      end
      if ((state == RD_LO) || (state == RD_HI)) begin
        sram_oe_n = 1'b0;
      end else begin
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        if (width_q == W8)        sram_dq_o = {2{wr_data_q[7:0]}};
        else if (state == WR_HI)  sram_dq_o = wr_data_q[31:16];
        else                      sram_dq_o = wr_data_q[15:0];
      end
    end
  end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if ((rd_accept || wr_accept) &&
                 misaligned(norm_width(mem.mem_data_width), mem.mem_addr[1:0])) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign mem_err = 1'b0;
`endif

endmodule
